// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: the WB stage has priority over one long-latency unit.
// It also keeps a busy scoreboard for hazard checks and stalls WB once when the LU is starved.
module regfile_wb_arbiter #(
    parameter int XLEN         = 32,
    parameter int NREG         = 32,
    parameter int AW           = 5,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pipe_we,
    input  logic [AW-1:0]   pipe_rd,
    input  logic [XLEN-1:0] pipe_wd,
    input  logic            lu_valid,
    input  logic [AW-1:0]   lu_rd,
    input  logic [XLEN-1:0] lu_wd,
    output logic            lu_ready,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    output logic            issue_ok,
    input  logic [AW-1:0]   chk_a1,
    input  logic [AW-1:0]   chk_a2,
    input  logic [AW-1:0]   chk_rd,
    output logic            hz1,
    output logic            hz2,
    output logic            hzd,
    output logic            stall_pipe,
    output logic            rf_we,
    output logic [AW-1:0]   rf_a3,
    output logic [XLEN-1:0] rf_wd,
    output logic [NREG-1:0] busy_vec,
    output logic            err
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIM    = CW'(STARVE_LIMIT);
    localparam logic [CW-1:0] LIM_M1 = CW'(STARVE_LIMIT - 1);

    logic [NREG-1:0] busy_q, busy_d;
    logic [CW-1:0]   starve_q, starve_d;
    logic            stall_q, stall_d;
    logic            err_q, err_d;
    logic            pw, grant, denied;

    // Write-port arbitration; the outputs stay combinational so the negedge RF write lands this cycle
    always_comb begin
        pw       = pipe_we && (pipe_rd != '0) && !stall_q;
        lu_ready = !reset && !pw;
        grant    = lu_valid && lu_ready;
        denied   = lu_valid && !lu_ready;
        rf_we    = 1'b0;
        rf_a3    = '0;
        rf_wd    = '0;
        if (!reset) begin
            if (pw) begin
                rf_we = 1'b1;
                rf_a3 = pipe_rd;
                rf_wd = pipe_wd;
            end else if (lu_valid) begin
                rf_we = (lu_rd != '0);
                rf_a3 = lu_rd;
                rf_wd = lu_wd;
            end
        end
    end

    always_comb begin
        busy_d = busy_q;
        if (grant && (lu_rd != '0))
            busy_d[lu_rd] = 1'b0;
        // The set is applied after the clear, so an issue wins over a same-cycle retire
        if (issue_valid && (issue_rd != '0))
            busy_d[issue_rd] = 1'b1;
        busy_d[0] = 1'b0;

        if (denied)
            starve_d = (starve_q == LIM) ? LIM : starve_q + CW'(1);
        else
            starve_d = '0;

        if (denied && (starve_q == LIM_M1))
            stall_d = 1'b1;
        else if (grant)
            stall_d = 1'b0;
        else
            stall_d = stall_q;

        err_d = err_q;
        if (issue_valid && (issue_rd != '0) && busy_q[issue_rd])
            err_d = 1'b1;
        if (pipe_we && (pipe_rd != '0) && (busy_q[pipe_rd] || stall_q))
            err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q   <= '0;
            starve_q <= '0;
            stall_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            busy_q   <= busy_d;
            starve_q <= starve_d;
            stall_q  <= stall_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        issue_ok   = !busy_q[issue_rd];
        hz1        = (chk_a1 != '0) && busy_q[chk_a1];
        hz2        = (chk_a2 != '0) && busy_q[chk_a2];
        hzd        = (chk_rd != '0) && busy_q[chk_rd];
        stall_pipe = stall_q;
        err        = err_q;
        busy_vec   = busy_q;
    end
endmodule
